// File: rtl/spi_master_multi.sv
// Full-duplex SPI master: runtime CPOL/CPHA, programmable SCLK divider, variable word length, burst frames.
// Latency: a word takes (2 + 2*bits) SCLK half-periods from accept to rx_valid. Each half-period is cfg_clk_div+1 clk cycles.
// Backpressure: tx_ready only in IDLE/HOLD, so a held frame stalls indefinitely in HOLD; rx_valid is a pulse with no backpressure.
module spi_master_multi #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_SLAVES = 4,
    parameter int DIV_WIDTH  = 8,
    parameter int SS_W       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
    parameter int LEN_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_cpol,
    input  logic                  cfg_cpha,
    input  logic [DIV_WIDTH-1:0]  cfg_clk_div,
    input  logic [LEN_W-1:0]      cfg_bits,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [SS_W-1:0]       tx_slave,
    input  logic                  tx_last,
    output logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_SLAVES-1:0] ss_n
);

    // The edge counter must reach 2*DATA_WIDTH, so it is one bit wider than the length field.
    localparam int EW = LEN_W + 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t                state_q, state_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [LEN_W-1:0]      bits_q, bits_d;
    logic                  last_q, last_d;
    logic [SS_W-1:0]       slave_q, slave_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [EW-1:0]         edge_q, edge_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic [NUM_SLAVES-1:0] ss_n_q, ss_n_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  tx_ready_q, tx_ready_d;

    logic                  tick;
    logic                  accept;
    logic [LEN_W-1:0]      eff_bits;
    logic [DATA_WIDTH-1:0] tx_aligned;
    logic [EW-1:0]         edge_total;
    logic                  sample_edge;
    logic [SS_W-1:0]       ss_sel;
    logic [NUM_SLAVES-1:0] ss_dec;

    assign tick       = (cnt_q == div_q);
    assign accept     = tx_valid && tx_ready_q;
    assign edge_total = {bits_q, 1'b0};
    // Leading edges have even index; cpha=0 samples on leading, cpha=1 on trailing.
    assign sample_edge = (edge_q[0] == cpha_q);

    // Effective word length and MSB-aligned transmit word for the incoming request.
    always_comb begin
        eff_bits = cfg_bits;
        if (cfg_bits == '0 || cfg_bits > LEN_W'(DATA_WIDTH)) begin
            eff_bits = LEN_W'(DATA_WIDTH);
        end
        tx_aligned = tx_data << (LEN_W'(DATA_WIDTH) - eff_bits);
    end

    // Slave select decode; the slave index is only taken from the bus on the first word of a frame.
    always_comb begin
        ss_sel = (state_q == IDLE) ? tx_slave : slave_q;
        ss_dec = '1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            ss_dec[i] = (ss_sel != SS_W'(i));
        end
    end

    // Next-state and datapath updates for the transfer FSM.
    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        div_d      = div_q;
        bits_d     = bits_q;
        last_d     = last_q;
        slave_d    = slave_q;
        cnt_d      = tick ? '0 : cnt_q + DIV_WIDTH'(1);
        edge_d     = edge_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                sclk_d = cfg_cpol;
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (edge_q == edge_total) begin
                        // Hold time after the final edge has elapsed: deliver the word.
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_sh_q;
                        if (last_q) begin
                            state_d = GAP;
                            ss_n_d  = '1;
                            mosi_d  = 1'b0;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        sclk_d = ~sclk_q;
                        edge_d = edge_q + EW'(1);
                        if (sample_edge) begin
                            rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], miso};
                        end else if (cpha_q || (edge_q + EW'(1)) != edge_total) begin
                            // cpha=0 has already presented bit 0 before the final trailing edge.
                            mosi_d  = tx_sh_q[DATA_WIDTH-1];
                            tx_sh_d = tx_sh_q << 1;
                        end
                    end
                end
            end
            HOLD: begin
                cnt_d = '0;
            end
            GAP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new word starts a fresh SETUP; ss_n stays asserted when arriving from HOLD.
        if (accept) begin
            state_d = SETUP;
            cpol_d  = cfg_cpol;
            cpha_d  = cfg_cpha;
            div_d   = cfg_clk_div;
            bits_d  = eff_bits;
            last_d  = tx_last;
            slave_d = ss_sel;
            ss_n_d  = ss_dec;
            sclk_d  = cfg_cpol;
            cnt_d   = '0;
            edge_d  = '0;
            rx_sh_d = '0;
            if (!cfg_cpha) begin
                mosi_d  = tx_aligned[DATA_WIDTH-1];
                tx_sh_d = tx_aligned << 1;
            end else begin
                tx_sh_d = tx_aligned;
            end
        end

        tx_ready_d = (state_d == IDLE) || (state_d == HOLD);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            div_q      <= '0;
            bits_q     <= '0;
            last_q     <= 1'b0;
            slave_q    <= '0;
            cnt_q      <= '0;
            edge_q     <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= '1;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            tx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            div_q      <= div_d;
            bits_q     <= bits_d;
            last_q     <= last_d;
            slave_q    <= slave_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = (state_q != IDLE);
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign ss_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi with an rx scoreboard, SCLK edge monitor and a small SPI slave model.
// Latency: n/a. Backpressure: n/a.
// Runs all SPI modes, bursts, length clamping, out-of-range slave and mid-transfer reset.
module tb_spi_master_multi;

    localparam int DW  = 16;
    localparam int NS  = 4;
    localparam int DVW = 8;
    localparam int SSW = 3;
    localparam int LW  = 5;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           cfg_cpol = 1'b0;
    logic           cfg_cpha = 1'b0;
    logic [DVW-1:0] cfg_clk_div = '0;
    logic [LW-1:0]  cfg_bits = '0;
    logic           tx_valid = 1'b0;
    logic           tx_ready;
    logic [DW-1:0]  tx_data = '0;
    logic [SSW-1:0] tx_slave = '0;
    logic           tx_last = 1'b0;
    logic           rx_valid;
    logic [DW-1:0]  rx_data;
    logic           busy;
    logic           sclk;
    logic           mosi;
    logic           miso;
    logic [NS-1:0]  ss_n;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_rx;

    // Edge monitor state
    int        cyc = 0;
    int        last_edge = 0;
    int        edge_cnt = 0;
    int        exp_half = 0;
    int        per_err = 0;
    int        ss_err = 0;
    logic [NS-1:0] exp_ss = '1;
    logic      prev_sclk = 1'b0;
    int        rx_cnt = 0;
    bit        hold_watch = 0;
    int        hold_until = 0;
    int        hold_err = 0;

    // Slave model state
    int        miso_sel = 0;
    bit        slv_en = 0;
    logic      s_cpol = 1'b0;
    logic      s_cpha = 1'b0;
    logic [DW-1:0] s_tx = '0;
    logic [DW-1:0] s_rx = '0;
    int        s_idx = 0;
    logic      s_out = 1'b0;

    int base;
    int n;

    assign miso = (miso_sel == 0) ? mosi : (miso_sel == 1) ? 1'b1 : s_out;

    spi_master_multi #(
        .DATA_WIDTH(DW), .NUM_SLAVES(NS), .DIV_WIDTH(DVW), .SS_W(SSW), .LEN_W(LW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_clk_div(cfg_clk_div), .cfg_bits(cfg_bits),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_slave(tx_slave), .tx_last(tx_last),
        .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
        .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
    );

    always #5 clk = ~clk;

    // Independent SPI slave: samples and drives on the edges its mode dictates.
    always @(sclk) begin
        if (slv_en) begin
            if ((sclk != s_cpol) == (s_cpha == 1'b0)) begin
                s_rx = {s_rx[DW-2:0], mosi};
            end else if (s_cpha) begin
                if (s_idx >= 0) s_out = s_tx[s_idx];
                s_idx = s_idx - 1;
            end else begin
                s_idx = s_idx - 1;
                if (s_idx >= 0) s_out = s_tx[s_idx];
            end
        end
    end

    // Monitor on the falling clk edge: SCLK edges, ss_n integrity, rx scoreboard.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (sclk !== prev_sclk) begin
            if (exp_half != 0 && edge_cnt != 0 && (cyc - last_edge) != exp_half) per_err = per_err + 1;
            if (ss_n !== exp_ss) ss_err = ss_err + 1;
            edge_cnt  = edge_cnt + 1;
            last_edge = cyc;
            prev_sclk = sclk;
        end
        if (hold_watch && rx_cnt < hold_until && rx_valid !== 1'b1 && ss_n !== 4'b1101) hold_err = hold_err + 1;
        if (rx_valid === 1'b1) begin
            vectors = vectors + 1;
            assert (exp_q.size() > 0) else begin
                miscompares = miscompares + 1;
                $error("FAIL rx_unexpected: observed rx_valid with data %0h, expected no word", rx_data);
            end
            if (exp_q.size() > 0) begin
                exp_rx = exp_q.pop_front();
                assert (rx_data === exp_rx) else begin
                    miscompares = miscompares + 1;
                    $error("FAIL rx_data: observed %0h expected %0h", rx_data, exp_rx);
                end
            end
            rx_cnt = rx_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors = vectors + 1;
        assert (obs === expv) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_mon();
        edge_cnt = 0;
        ss_err   = 0;
        per_err  = 0;
        hold_err = 0;
    endtask

    task automatic set_cfg(input logic cpol, input logic cpha, input logic [DVW-1:0] div);
        @(negedge clk);
        cfg_cpol    = cpol;
        cfg_cpha    = cpha;
        cfg_clk_div = div;
        repeat (4) @(negedge clk);
        clear_mon();
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [LW-1:0] bits, input logic [SSW-1:0] sl,
                        input logic last, input logic [DW-1:0] expv, input bit push);
        int k;
        k = 0;
        if (push) exp_q.push_back(expv);
        @(negedge clk);
        tx_data  = d;
        cfg_bits = bits;
        tx_slave = sl;
        tx_last  = last;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("tx_accept_timeout", (k < 2000), 1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", (k < 5000), 1'b1);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_ss_n", ss_n, 4'hF);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 16'h0000);
        reset_n = 1'b1;

        // Mode 0, 8 bits, div=1, loopback
        miso_sel = 0;
        set_cfg(1'b0, 1'b0, 8'd1);
        exp_ss   = 4'b1110;
        exp_half = 2;
        send(16'h00A5, 5'd8, 3'd0, 1'b1, 16'h00A5, 1);
        @(negedge clk);
        check("m0_busy", busy, 1'b1);
        check("m0_ss_active", ss_n, 4'b1110);
        wait_idle();
        check("m0_edges", edge_cnt, 16);
        check("m0_period", per_err, 0);
        check("m0_ss", ss_err, 0);
        check("m0_ss_release", ss_n, 4'hF);
        check("m0_rx_count", rx_cnt, 1);
        exp_half = 0;

        // Mode 3, 16 bits, div=0, slave 2, miso tied high
        miso_sel = 1;
        set_cfg(1'b1, 1'b1, 8'd0);
        check("m3_sclk_idle_pre", sclk, 1'b1);
        exp_ss = 4'b1011;
        send(16'h1234, 5'd16, 3'd2, 1'b1, 16'hFFFF, 1);
        wait_idle();
        check("m3_edges", edge_cnt, 32);
        check("m3_ss", ss_err, 0);
        check("m3_sclk_idle_post", sclk, 1'b1);

        // Burst of three words on slave 1; later words carry other slave indices that must be ignored
        miso_sel = 0;
        set_cfg(1'b0, 1'b0, 8'd1);
        exp_ss = 4'b1101;
        base   = rx_cnt;
        send(16'h0011, 5'd8, 3'd1, 1'b0, 16'h0011, 1);
        n = 0;
        while (ss_n !== 4'b1101 && n < 100) begin
            @(negedge clk);
            n++;
        end
        hold_until = base + 3;
        hold_watch = 1;
        send(16'h0022, 5'd8, 3'd3, 1'b0, 16'h0022, 1);
        send(16'h0033, 5'd8, 3'd0, 1'b1, 16'h0033, 1);
        wait_idle();
        hold_watch = 0;
        check("burst_rx_count", rx_cnt - base, 3);
        check("burst_ss_held", hold_err, 0);
        check("burst_ss_edges", ss_err, 0);
        check("burst_edges", edge_cnt, 48);
        check("burst_ss_release", ss_n, 4'hF);

        // Mode 1 against slave model, 5 bits
        miso_sel = 2;
        slv_en   = 0;
        set_cfg(1'b0, 1'b1, 8'd2);
        s_cpol = 1'b0; s_cpha = 1'b1; s_tx = 16'h000A; s_rx = '0; s_idx = 4; s_out = 1'b0;
        slv_en = 1;
        exp_ss = 4'b1110;
        send(16'h0015, 5'd5, 3'd0, 1'b1, 16'h000A, 1);
        wait_idle();
        slv_en = 0;
        check("m1_slave_rx", s_rx[4:0], 5'h15);
        check("m1_edges", edge_cnt, 10);
        check("m1_ss", ss_err, 0);

        // Mode 2 against slave model, 5 bits
        set_cfg(1'b1, 1'b0, 8'd2);
        s_cpol = 1'b1; s_cpha = 1'b0; s_tx = 16'h000A; s_rx = '0; s_idx = 4; s_out = s_tx[4];
        slv_en = 1;
        send(16'h0015, 5'd5, 3'd0, 1'b1, 16'h000A, 1);
        wait_idle();
        slv_en = 0;
        check("m2_slave_rx", s_rx[4:0], 5'h15);
        check("m2_edges", edge_cnt, 10);

        // Length clamping and out-of-range slave index
        miso_sel = 0;
        set_cfg(1'b0, 1'b0, 8'd0);
        exp_ss = 4'b1110;
        send(16'hBEEF, 5'd0, 3'd0, 1'b1, 16'hBEEF, 1);
        wait_idle();
        check("bits0_edges", edge_cnt, 32);
        clear_mon();
        send(16'h1357, 5'd20, 3'd0, 1'b1, 16'h1357, 1);
        wait_idle();
        check("bits20_edges", edge_cnt, 32);
        check("bits_ss", ss_err, 0);
        clear_mon();
        exp_ss = 4'hF;
        send(16'hC3C3, 5'd16, 3'd5, 1'b1, 16'hC3C3, 1);
        wait_idle();
        check("slave5_edges", edge_cnt, 32);
        check("slave5_no_ss", ss_err, 0);

        // Reset in the middle of a mode-3 transfer
        set_cfg(1'b1, 1'b1, 8'd3);
        base = rx_cnt;
        send(16'h005A, 5'd8, 3'd0, 1'b1, 16'h0000, 0);
        n = 0;
        while (edge_cnt < 8 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reach", (n < 1000), 1'b1);
        reset_n = 1'b0;
        @(negedge clk);
        check("rstm_sclk", sclk, 1'b0);
        check("rstm_ss_n", ss_n, 4'hF);
        check("rstm_busy", busy, 1'b0);
        check("rstm_tx_ready", tx_ready, 1'b0);
        check("rstm_mosi", mosi, 1'b0);
        check("rstm_rx_data", rx_data, 16'h0000);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rstm_no_rx", rx_cnt - base, 0);

        // Normal transfer after reset
        set_cfg(1'b0, 1'b0, 8'd1);
        exp_ss = 4'b1110;
        send(16'h003C, 5'd8, 3'd0, 1'b1, 16'h003C, 1);
        wait_idle();
        check("post_rst_edges", edge_cnt, 16);
        check("post_rst_ss", ss_err, 0);
        check("post_rst_rx_count", rx_cnt - base, 1);
        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
